// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM main control FSM:
// state encoding, datapath mux-select encodings and the per-state
// Moore control word.
package arm_mc_pkg;

    // Main FSM states; FETCH must be encoding 0.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FPEXEC   = 4'd10
    } state_e;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // AdrSrc encodings
    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    // ALUSrcA encodings
    localparam logic SRCA_RD1 = 1'b0;
    localparam logic SRCA_PC  = 1'b1;

    // Moore control word driven by the FSM each cycle.
    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       aluop;
    } ctrl_t;

    // Held while reset is asserted: every strobe low, mux selects at their
    // FETCH values so the PC+4 path is already set up on release.
    localparam ctrl_t CTRL_RESET = '{
        irwrite:   1'b0,
        adrsrc:    ADR_PC,
        alusrca:   SRCA_PC,
        alusrcb:   SRCB_FOUR,
        resultsrc: RES_ALU,
        nextpc:    1'b0,
        regw:      1'b0,
        memw:      1'b0,
        branch:    1'b0,
        aluop:     1'b0
    };

    // Control word for a given state; anything not set here is 0.
    function automatic ctrl_t moore_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
                c.adrsrc    = ADR_PC;
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALU;
            end
            S_DECODE: begin
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALU;
            end
            S_MEMADR:   c.alusrcb = SRCB_EXTIMM;
            S_MEMREAD:  c.adrsrc  = ADR_ALUOUT;
            S_MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regw      = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc = ADR_ALUOUT;
                c.memw   = 1'b1;
            end
            S_EXECR:    c.aluop = 1'b1;
            S_EXECI: begin
                c.alusrcb = SRCB_EXTIMM;
                c.aluop   = 1'b1;
            end
            S_ALUWB:    c.regw = 1'b1;
            S_BRANCH: begin
                c.alusrcb   = SRCB_EXTIMM;
                c.resultsrc = RES_ALU;
                c.branch    = 1'b1;
            end
            S_FPEXEC:   c.aluop = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fp_wait_timer.sv
// Counts cycles spent waiting on the FPU and flags when the wait budget
// (FP_TIMEOUT cycles) is used up. clr has priority over en.
module fp_wait_timer #(
    parameter int FP_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_q;

    // Wait-cycle counter: zero outside the wait, +1 per waiting cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else if (clr) begin
            count_q <= 8'd0;
        end else if (en) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Final permitted wait cycle is the one where the count reads FP_TIMEOUT-1.
    assign expired = en && (count_q == 8'(FP_TIMEOUT - 1));

endmodule

// File: rtl/arm_mainfsm.sv
// Multicycle main control FSM for the ARM core.
// Optional FPU handshake (FPEXEC state, wait timer, fpu_start, fp_err) is
// built only when ARM_MC_FPU_EN is defined; otherwise FP register forms
// execute through EXECR and fpu_start/fp_err read 0.
module arm_mainfsm
    import arm_mc_pkg::*;
#(
    parameter int FP_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        fp,
    input  logic        fpu_done,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        NextPC,
    output logic        RegW,
    output logic        MemW,
    output logic        Branch,
    output logic        ALUOp,
    output logic        fpu_start,
    output logic        fp_err,
    output logic        undef,
    output logic [31:0] instret
);

    state_e      state_q;
    state_e      state_d;
    ctrl_t       ctrl_q;
    logic [31:0] instret_q;
    logic        retire;
    logic        unused_ok;

`ifdef ARM_MC_FPU_EN
    logic timer_expired;
    logic fp_timeout;
    logic fpu_start_q;
    logic fp_err_q;

    fp_wait_timer #(
        .FP_TIMEOUT (FP_TIMEOUT)
    ) u_fp_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != S_FPEXEC),
        .en      (state_q == S_FPEXEC),
        .expired (timer_expired)
    );

    // A done pulse in the last wait cycle still counts as completion.
    assign fp_timeout = (state_q == S_FPEXEC) && !fpu_done && timer_expired;
    assign unused_ok  = ^Funct[4:1];
`else
    assign unused_ok  = ^{Funct[4:1], fp, fpu_done, 8'(FP_TIMEOUT)};
`endif

    // Instructions that complete normally all pass through one of these.
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                    (state_q == S_ALUWB) || (state_q == S_BRANCH);

    // Next-state logic. FETCH only advances once its strobes have actually
    // been driven, so the cycle after reset release is a full FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = ctrl_q.irwrite ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00: begin
                        if (Funct[5]) begin
                            state_d = S_EXECI;
                        end else begin
`ifdef ARM_MC_FPU_EN
                            state_d = fp ? S_FPEXEC : S_EXECR;
`else
                            state_d = S_EXECR;
`endif
                        end
                    end
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
`ifdef ARM_MC_FPU_EN
            S_FPEXEC: begin
                if (fpu_done) begin
                    state_d = S_ALUWB;
                end else if (timer_expired) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // State, registered Moore outputs, retire counter and FPU flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            ctrl_q      <= CTRL_RESET;
            instret_q   <= 32'd0;
`ifdef ARM_MC_FPU_EN
            fpu_start_q <= 1'b0;
            fp_err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
`ifdef ARM_MC_FPU_EN
            fpu_start_q <= (state_q == S_DECODE) && (state_d == S_FPEXEC);
            if (fp_timeout) begin
                fp_err_q <= 1'b1;
            end
`endif
        end
    end

    assign IRWrite   = ctrl_q.irwrite;
    assign AdrSrc    = ctrl_q.adrsrc;
    assign ALUSrcA   = ctrl_q.alusrca;
    assign ALUSrcB   = ctrl_q.alusrcb;
    assign ResultSrc = ctrl_q.resultsrc;
    assign NextPC    = ctrl_q.nextpc;
    assign RegW      = ctrl_q.regw;
    assign MemW      = ctrl_q.memw;
    assign Branch    = ctrl_q.branch;
    assign ALUOp     = ctrl_q.aluop;
    assign instret   = instret_q;

    // Op only holds the decoded instruction during DECODE, so this is Mealy.
    assign undef     = (state_q == S_DECODE) && (Op == 2'b11);

`ifdef ARM_MC_FPU_EN
    assign fpu_start = fpu_start_q;
    assign fp_err    = fp_err_q;
`else
    assign fpu_start = 1'b0;
    assign fp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_arm_mainfsm.sv
// Scoreboard bench for arm_mainfsm: per-cycle expected control vectors are
// queued while building each instruction sequence, then popped and checked.
module tb_arm_mainfsm;

    localparam int TO = 16;
`ifdef ARM_MC_FPU_EN
    localparam bit FPU = 1'b1;
`else
    localparam bit FPU = 1'b0;
`endif

    localparam int B_FETCH = 0, B_DECODE = 1, B_MEMADR = 2, B_MEMREAD = 3,
                   B_MEMWB = 4, B_MEMWRITE = 5, B_EXECR = 6, B_EXECI = 7,
                   B_ALUWB = 8, B_BRANCH = 9, B_FPEXEC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [5:0]  Funct = 6'b0;
    logic        fp = 1'b0;
    logic        fpu_done = 1'b0;
    logic        IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
    logic        fpu_start, fp_err, undef;
    logic [1:0]  ALUSrcB, ResultSrc;
    logic [31:0] instret;
    logic [14:0] vec;

    arm_mainfsm #(.FP_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .fp(fp),
        .fpu_done(fpu_done), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .ALUOp(ALUOp), .fpu_start(fpu_start), .fp_err(fp_err),
        .undef(undef), .instret(instret)
    );

    always #5 clk = ~clk;

    assign vec = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
                  RegW, MemW, Branch, ALUOp, fpu_start, fp_err, undef};

    typedef struct {
        logic [14:0] v;
        logic [1:0]  op;
        logic [5:0]  f;
        logic        fpv;
        logic        done;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_ret = 32'd0;
    logic [1:0]  cur_op = 2'b00;
    logic [5:0]  cur_f = 6'b0;
    logic        cur_fp = 1'b0;

    // Expected output vector per state, straight from the output table.
    function automatic logic [14:0] model_vec(int st, logic u, logic s, logic e);
        logic irw, adr, sa, np, rw, mw, br, ao;
        logic [1:0] sb, rs;
        irw = 0; adr = 0; sa = 0; np = 0; rw = 0; mw = 0; br = 0; ao = 0;
        sb = 2'b00; rs = 2'b00;
        case (st)
            B_FETCH:    begin irw = 1; np = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
            B_DECODE:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
            B_MEMADR:   sb = 2'b01;
            B_MEMREAD:  adr = 1;
            B_MEMWB:    begin rs = 2'b01; rw = 1; end
            B_MEMWRITE: begin adr = 1; mw = 1; end
            B_EXECR:    ao = 1;
            B_EXECI:    begin sb = 2'b01; ao = 1; end
            B_ALUWB:    rw = 1;
            B_BRANCH:   begin sb = 2'b01; rs = 2'b10; br = 1; end
            B_FPEXEC:   ao = 1;
            default:    ;
        endcase
        return {irw, adr, sa, sb, rs, np, rw, mw, br, ao, s, e, u};
    endfunction

    function automatic logic [14:0] reset_vec();
        return {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 8'b0};
    endfunction

    task automatic push(int st, logic u, logic s, logic d);
        exp_t e;
        e.v = model_vec(st, u, s, exp_err);
        e.op = cur_op; e.f = cur_f; e.fpv = cur_fp; e.done = d;
        q.push_back(e);
    endtask

    // Expected cycle sequence of one instruction. done_at: FPEXEC cycle
    // (1-based) with fpu_done high, 0 = never. noise drives fpu_done on
    // every non-FPEXEC cycle.
    task automatic push_instr(logic [1:0] op, logic [5:0] f, logic fpv,
                              int done_at, logic noise);
        bit fin;
        cur_op = op; cur_f = f; cur_fp = fpv;
        push(B_FETCH, 0, 0, noise);
        push(B_DECODE, op == 2'b11, 0, noise);
        case (op)
            2'b01: begin
                push(B_MEMADR, 0, 0, noise);
                if (f[0]) begin
                    push(B_MEMREAD, 0, 0, noise);
                    push(B_MEMWB, 0, 0, noise);
                end else begin
                    push(B_MEMWRITE, 0, 0, noise);
                end
                exp_ret++;
            end
            2'b10: begin
                push(B_BRANCH, 0, 0, noise);
                exp_ret++;
            end
            2'b11: ;
            default: begin
                if (f[5]) begin
                    push(B_EXECI, 0, 0, noise);
                    push(B_ALUWB, 0, 0, noise);
                    exp_ret++;
                end else if (fpv && FPU) begin
                    fin = 0;
                    for (int k = 1; k <= TO; k++) begin
                        if (!fin) begin
                            push(B_FPEXEC, 0, k == 1, k == done_at);
                            if (k == done_at) begin
                                push(B_ALUWB, 0, 0, noise);
                                fin = 1;
                                exp_ret++;
                            end
                        end
                    end
                    if (!fin) exp_err = 1'b1;
                end else begin
                    push(B_EXECR, 0, 0, noise);
                    push(B_ALUWB, 0, 0, noise);
                    exp_ret++;
                end
            end
        endcase
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (vec !== reset_vec()) begin
            bad++; $display("FAIL reset_hold: vec=%h expected %h", vec, reset_vec());
        end
        total++;
        if (instret !== 32'd0) begin
            bad++; $display("FAIL reset_instret: instret=%0d expected 0", instret);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (vec !== reset_vec()) begin
            bad++; $display("FAIL release_before_edge: vec=%h expected %h", vec, reset_vec());
        end
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (vec !== model_vec(B_FETCH, 0, 0, 0)) begin
            bad++; $display("FAIL first_fetch: vec=%h expected %h", vec, model_vec(B_FETCH, 0, 0, 0));
        end
        $display("txn reset: vec=%h instret=%0d", vec, instret);
    endtask

    task automatic test_ldr();
        exp_t e;
        int c = 0;
        push_instr(2'b01, 6'b011001, 0, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            Op = e.op; Funct = e.f; fp = e.fpv; fpu_done = e.done;
            #1;
            total++;
            if (vec !== e.v) begin
                bad++; $display("FAIL ldr cyc%0d: vec=%h expected %h", c, vec, e.v);
            end else $display("txn ldr cyc%0d vec=%h", c, vec);
            c++;
            @(posedge clk); @(negedge clk);
        end
        fpu_done = 0;
        total++;
        if (instret !== exp_ret) begin
            bad++; $display("FAIL ldr_instret: instret=%0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_str_addi();
        exp_t e;
        int c = 0;
        push_instr(2'b01, 6'b011000, 0, 0, 0);
        push_instr(2'b00, 6'b101000, 0, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            Op = e.op; Funct = e.f; fp = e.fpv; fpu_done = e.done;
            #1;
            total++;
            if (vec !== e.v) begin
                bad++; $display("FAIL str_addi cyc%0d: vec=%h expected %h", c, vec, e.v);
            end else $display("txn str_addi cyc%0d vec=%h", c, vec);
            c++;
            @(posedge clk); @(negedge clk);
        end
        fpu_done = 0;
        total++;
        if (instret !== exp_ret) begin
            bad++; $display("FAIL str_addi_instret: instret=%0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_branch_undef();
        exp_t e;
        int c = 0;
        push_instr(2'b10, 6'b000000, 0, 0, 0);
        push_instr(2'b11, 6'b000000, 0, 0, 0);
        push_instr(2'b00, 6'b000100, 0, 0, 1);   // register DP with stray fpu_done
        while (q.size() > 0) begin
            e = q.pop_front();
            Op = e.op; Funct = e.f; fp = e.fpv; fpu_done = e.done;
            #1;
            total++;
            if (vec !== e.v) begin
                bad++; $display("FAIL branch_undef cyc%0d: vec=%h expected %h", c, vec, e.v);
            end else $display("txn branch_undef cyc%0d vec=%h", c, vec);
            c++;
            @(posedge clk); @(negedge clk);
        end
        fpu_done = 0;
        total++;
        if (instret !== exp_ret) begin
            bad++; $display("FAIL branch_undef_instret: instret=%0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_fp_done();
        exp_t e;
        int c = 0;
        push_instr(2'b00, 6'b000100, 1, 4, 0);   // done 3 cycles after start
        push_instr(2'b00, 6'b000100, 1, 1, 0);   // done with start: N=1
        push_instr(2'b00, 6'b000100, 1, TO, 0);  // done on the timeout cycle
        while (q.size() > 0) begin
            e = q.pop_front();
            Op = e.op; Funct = e.f; fp = e.fpv; fpu_done = e.done;
            #1;
            total++;
            if (vec !== e.v) begin
                bad++; $display("FAIL fp_done cyc%0d: vec=%h expected %h", c, vec, e.v);
            end else $display("txn fp_done cyc%0d vec=%h", c, vec);
            c++;
            @(posedge clk); @(negedge clk);
        end
        fpu_done = 0;
        total++;
        if (instret !== exp_ret) begin
            bad++; $display("FAIL fp_done_instret: instret=%0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_fp_timeout();
        exp_t e;
        int c = 0;
        push_instr(2'b00, 6'b000100, 1, 0, 0);
        push_instr(2'b00, 6'b101000, 0, 0, 0);
        push_instr(2'b10, 6'b000000, 0, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            Op = e.op; Funct = e.f; fp = e.fpv; fpu_done = e.done;
            #1;
            total++;
            if (vec !== e.v) begin
                bad++; $display("FAIL fp_timeout cyc%0d: vec=%h expected %h", c, vec, e.v);
            end else $display("txn fp_timeout cyc%0d vec=%h", c, vec);
            c++;
            @(posedge clk); @(negedge clk);
        end
        fpu_done = 0;
        total++;
        if (instret !== exp_ret) begin
            bad++; $display("FAIL fp_timeout_instret: instret=%0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_reset_mid_memwrite();
        exp_t e;
        int c = 0;
        cur_op = 2'b01; cur_f = 6'b011000; cur_fp = 0;
        push(B_FETCH, 0, 0, 0);
        push(B_DECODE, 0, 0, 0);
        push(B_MEMADR, 0, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            Op = e.op; Funct = e.f; fp = e.fpv; fpu_done = e.done;
            #1;
            total++;
            if (vec !== e.v) begin
                bad++; $display("FAIL mid_reset cyc%0d: vec=%h expected %h", c, vec, e.v);
            end else $display("txn mid_reset cyc%0d vec=%h", c, vec);
            c++;
            @(posedge clk); @(negedge clk);
        end
        #1;
        total++;
        if (vec !== model_vec(B_MEMWRITE, 0, 0, exp_err)) begin
            bad++; $display("FAIL memwrite_before_reset: vec=%h expected %h", vec, model_vec(B_MEMWRITE, 0, 0, exp_err));
        end
        #1 reset = 1'b0;
        #1;
        exp_ret = 32'd0;
        exp_err = 1'b0;
        total++;
        if (vec !== reset_vec()) begin
            bad++; $display("FAIL async_reset_vec: vec=%h expected %h", vec, reset_vec());
        end
        total++;
        if (instret !== exp_ret) begin
            bad++; $display("FAIL async_reset_instret: instret=%0d expected 0", instret);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        total++;
        if (vec !== model_vec(B_FETCH, 0, 0, 0)) begin
            bad++; $display("FAIL refetch: vec=%h expected %h", vec, model_vec(B_FETCH, 0, 0, 0));
        end
        $display("txn mid_reset: refetch vec=%h instret=%0d", vec, instret);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ldr();
        test_str_addi();
        test_branch_undef();
        test_fp_done();
        test_fp_timeout();
        test_reset_mid_memwrite();
        test_ldr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_mainfsm.md
# arm_mainfsm

Multicycle main control FSM for the ARM core. It is the sequencing controller that replaces single-cycle operation: one instruction is spread over 3–5 cycles, and the shared ALU, memory port and register-file write port are reused across states. It sits in the controller next to `decode`'s ALU-decoder half and `condlogic`. Its `RegW`/`MemW`/`Branch` strobes are gated by the condition logic before reaching the datapath, and it handshakes with a multicycle FPU.

## Interface
- `FP_TIMEOUT`, 16: maximum cycles spent in FPEXEC waiting for `fpu_done`. Legal range 2..255.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `Op` in 2: Instr[27:26].
- `Funct` in 6: Instr[25:20].
- `fp` in 1: FP data-processing instruction (Instr[7:5]==3'b111).
- `fpu_done` in 1: FPU result valid, one-cycle pulse.
- `IRWrite` out 1: load instruction register.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ALUSrcA` out 1: 0 = RD1, 1 = PC.
- `ALUSrcB` out 2: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data reg, 10 = ALU result direct.
- `NextPC` out 1: unconditional PC write.
- `RegW`, `MemW`, `Branch` out 1 each: pre-condition strobes to condlogic.
- `ALUOp` out 1: enable the ALU decoder.
- `fpu_start` out 1: start FPU, one-cycle pulse.
- `fp_err` out 1: sticky FPU timeout flag.
- `undef` out 1: one-cycle pulse on Op=11.
- `instret` out 32: retired-instruction counter.

## Operation
- 4-bit state register. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, FPEXEC.
- Moore outputs. Any signal not listed for a state is 0.
  - FETCH: `IRWrite`, `NextPC`; `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
  - DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
  - MEMADR: `ALUSrcB`=01.
  - MEMREAD: `AdrSrc`=1.
  - MEMWB: `ResultSrc`=01, `RegW`.
  - MEMWRITE: `AdrSrc`=1, `MemW`.
  - EXECR: `ALUOp`.
  - EXECI: `ALUSrcB`=01, `ALUOp`.
  - ALUWB: `RegW`.
  - BRANCH: `ALUSrcB`=01, `ResultSrc`=10, `Branch`.
  - FPEXEC: `ALUOp`.
- Transitions:
  - FETCH→DECODE.
  - DECODE:
    - Op=00 with Funct[5]=1 → EXECI.
    - Op=00 with Funct[5]=0 → FPEXEC if `fp`, else EXECR.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=11 → FETCH, with `undef`=1 during that DECODE cycle.
  - MEMADR: Funct[0] → MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECR, EXECI → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH.
  - FPEXEC:
    - `fpu_done` → ALUWB.
    - Wait counter reaching FP_TIMEOUT−1 without `fpu_done` → FETCH, and `fp_err` is set.
- `fpu_start` is asserted only in the first FPEXEC cycle, i.e. the cycle after DECODE.
- `instret` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or FPEXEC-done. A timeout or undef exit does not increment it. It wraps 0xFFFFFFFF→0.

## Timing
- Latency, FETCH to FETCH:
  - LDR 5 cycles; STR 4; DP 4; B 3.
  - FP op: 3 + N, where N is the number of FPEXEC cycles. Minimum N is 1, when `fpu_done` arrives in the same cycle as `fpu_start`.
- Reset asserted asynchronously forces, immediately:
  - state = FETCH, `instret` = 0, `fp_err` = 0, FP wait counter = 0.
  - All strobe outputs (`IRWrite`, `NextPC`, `RegW`, `MemW`, `Branch`, `ALUOp`, `fpu_start`, `undef`) = 0.
  - Mux selects hold their FETCH values.
- After reset is released, the first rising edge is a FETCH cycle with strobes active.
- Reset asserted mid-instruction aborts it. No write strobe may glitch high during reset.
- An `fpu_done` arriving outside FPEXEC is ignored.
- `fpu_done` and timeout in the same cycle: done wins; `fp_err` is not set.
- `fp_err` clears only on reset.

## Configuration
- `ARM_MC_FPU_EN` defined:
  - FPEXEC state, wait counter, `fpu_start` and `fp_err` logic are present.
- `ARM_MC_FPU_EN` undefined:
  - `fp` is ignored; Op=00 register forms go to EXECR, i.e. the FPU is treated as combinational.
  - `fpu_start` and `fp_err` are tied to 0.
  - FPEXEC encoding is unused; an illegal state returns to FETCH.

## Structure
- Package `arm_mc_pkg` holds:
  - The state enum (4-bit, FETCH = 0).
  - ALUSrcB and ResultSrc encoding constants.
  - The AdrSrc encoding.
- Sub-module `fp_wait_timer` holds the FPEXEC cycle counter and the timeout compare. Ports: `clk`, `reset`, `clr`, `en`, `expired`. It is instantiated only under `ARM_MC_FPU_EN`.

## Test plan
- Reset low mid-MEMWRITE → state FETCH, `MemW`=0 immediately; after release the first edge asserts `IRWrite`/`NextPC`; `instret`=0.
- LDR (Op=01, Funct=011001) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `RegW` high only in cycle 5 with `ResultSrc`=01; `instret` +1.
- STR (Funct[0]=0), then ADD immediate (Op=00, Funct=101000) → `MemW` in cycle 4 with `AdrSrc`=1; then EXECI with `ALUSrcB`=01 followed by ALUWB; `instret` +2.
- B (Op=10) then Op=11 → BRANCH with `Branch`=1, `ResultSrc`=10 in cycle 3; then `undef` pulses in DECODE, next state FETCH, `instret` unchanged.
- FP op with `fpu_done` 3 cycles after `fpu_start` → `fpu_start` pulses exactly once, FPEXEC lasts 4 cycles, then ALUWB, `fp_err`=0.
- FP op with no `fpu_done` and FP_TIMEOUT=16 → 16 FPEXEC cycles, return to FETCH, `fp_err`=1 and sticky across later instructions. Built without `ARM_MC_FPU_EN`, the same stimulus takes the EXECR path.
